// File: rtl/minifloat_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the 8-bit minifloat (1 sign, 3 exponent, 4 fraction, hidden 1) divider.
package minifloat_pkg;
  localparam int unsigned SIGN_W  = 1;
  localparam int unsigned EXP_W   = 3;
  localparam int unsigned FRAC_W  = 4;
  localparam int unsigned MF_W    = SIGN_W + EXP_W + FRAC_W;
  localparam int          EXP_BIAS_DEFAULT = 3;

  localparam logic [MF_W-1:0] MF_ZERO    = 8'h00;
  localparam logic [MF_W-2:0] MF_MAX_MAG = 7'h7F;

  // Mantissa quotient bits produced by the restoring divider (Q0..Q5).
  localparam int unsigned DIV_STEPS = 6;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;
endpackage

// File: rtl/minifloat_divider_if.sv
`timescale 1ns/1ps
// Operand/result handshake bundle of the minifloat divider.
interface minifloat_divider_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic       div_by_zero;
  logic       overflow;
  logic       underflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero, overflow, underflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero, overflow, underflow
  );
endinterface

// File: rtl/mf_div_step.sv
`timescale 1ns/1ps
// One restoring division step on the 6-bit partial remainder.
module mf_div_step (
  input  logic [5:0] r,
  input  logic [4:0] d,
  output logic [5:0] r_next,
  output logic       q_bit
);
  logic [5:0] diff;

  always_comb begin
    q_bit  = (r >= {1'b0, d});
    diff   = q_bit ? (r - {1'b0, d}) : r;
    r_next = diff << 1;
  end
endmodule

// File: rtl/minifloat_divider.sv
`timescale 1ns/1ps
// Multi-cycle minifloat divider: restoring mantissa division, then one-cycle normalise/pack.
module minifloat_divider
  import minifloat_pkg::*;
#(
  parameter int EXP_BIAS = EXP_BIAS_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  minifloat_divider_if.slave bus
);
  state_t      state;
  logic [2:0]  step_cnt;
  logic [5:0]  rem;
  logic [4:0]  div_d;
  logic [5:0]  quot;
  logic        sign;
  logic [2:0]  ea;
  logic [2:0]  eb;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [7:0]  q_r;
  logic        dz_r;
  logic        ov_r;
  logic        uf_r;

  logic [5:0]        rem_next;
  logic              q_bit;
  logic [3:0]        frac;
  logic              adj;
  logic signed [4:0] e_res;

  mf_div_step u_step (
    .r      (rem),
    .d      (div_d),
    .r_next (rem_next),
    .q_bit  (q_bit)
  );

  // Quotient lies in (0.5, 2): Q0 tells whether a one-place left shift is needed.
  always_comb begin
    frac  = quot[5] ? quot[4:1] : quot[3:0];
    adj   = ~quot[5];
    e_res = 5'({2'b00, ea}) - 5'({2'b00, eb}) + 5'(EXP_BIAS) - 5'(adj);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step_cnt    <= '0;
      rem         <= '0;
      div_d       <= '0;
      quot        <= '0;
      sign        <= 1'b0;
      ea          <= '0;
      eb          <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= MF_ZERO;
      dz_r        <= 1'b0;
      ov_r        <= 1'b0;
      uf_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            dz_r       <= 1'b0;
            ov_r       <= 1'b0;
            uf_r       <= 1'b0;
            sign       <= bus.a[7] ^ bus.b[7];
            ea         <= bus.a[6:4];
            eb         <= bus.b[6:4];
            if (bus.b == MF_ZERO) begin
              q_r         <= {bus.a[7] ^ bus.b[7], MF_MAX_MAG};
              dz_r        <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else if (bus.a == MF_ZERO) begin
              q_r         <= MF_ZERO;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              rem      <= {2'b01, bus.a[3:0]};
              div_d    <= {1'b1, bus.b[3:0]};
              quot     <= '0;
              step_cnt <= '0;
              state    <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem      <= rem_next;
          quot     <= {quot[4:0], q_bit};
          step_cnt <= step_cnt + 3'd1;
          if (step_cnt == 3'(DIV_STEPS - 1)) state <= NORM;
        end
        NORM: begin
          if (e_res > 5'sd7) begin
            q_r  <= {sign, MF_MAX_MAG};
            ov_r <= 1'b1;
          end else if (e_res < 5'sd0) begin
            q_r  <= MF_ZERO;
            uf_r <= 1'b1;
          end else begin
            q_r <= {sign, e_res[2:0], frac};
          end
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.q           = q_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ov_r;
  assign bus.underflow   = uf_r;
endmodule

// File: tb/tb_minifloat_divider.sv
`timescale 1ns/1ps
// Self-checking bench for minifloat_divider: directed table, corner sequences, random vs model.
module tb_minifloat_divider;
  import minifloat_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  minifloat_divider_if bus();

  minifloat_divider #(.EXP_BIAS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] q;
    logic       dz;
    logic       ov;
    logic       uf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    res_t       exp_res;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: real mantissa ratio scaled by 32 and floored, then normalised.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int ma, mb, qq, e, adj;
    logic s;
    logic [3:0] frac;
    r = '0;
    s = a[7] ^ b[7];
    if (b == 8'h00) begin
      r.q  = {s, 7'h7F};
      r.dz = 1'b1;
      return r;
    end
    if (a == 8'h00) return r;
    ma = 16 + int'(a[3:0]);
    mb = 16 + int'(b[3:0]);
    qq = (ma * 32) / mb;
    if (qq >= 32) begin
      frac = 4'((qq / 2) % 16);
      adj  = 0;
    end else begin
      frac = 4'(qq % 16);
      adj  = 1;
    end
    e = int'(a[6:4]) - int'(b[6:4]) + 3 - adj;
    if (e > 7) begin
      r.q  = {s, 7'h7F};
      r.ov = 1'b1;
    end else if (e < 0) begin
      r.uf = 1'b1;
    end else begin
      r.q = {s, 3'(e), frac};
    end
    return r;
  endfunction

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) check("out_valid_timeout", 32'(lat), 32'd0);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_cleared", 32'(bus.out_valid), 32'd0);
    check("in_ready_restored", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_res(input string name, input res_t exp);
    check({name, "_q"},  32'(bus.q),           32'(exp.q));
    check({name, "_dz"}, 32'(bus.div_by_zero), 32'(exp.dz));
    check({name, "_ov"}, 32'(bus.overflow),    32'(exp.ov));
    check({name, "_uf"}, 32'(bus.underflow),   32'(exp.uf));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    int   lat;
    int   ov_cnt;
    logic [7:0] ra, rb;
    res_t exp_r;

    vecs[0] = '{8'h38, 8'h30, '{8'h38, 1'b0, 1'b0, 1'b0}, 7};
    vecs[1] = '{8'h30, 8'h38, '{8'h25, 1'b0, 1'b0, 1'b0}, 7};
    vecs[2] = '{8'hB8, 8'h30, '{8'hB8, 1'b0, 1'b0, 1'b0}, 7};
    vecs[3] = '{8'h70, 8'h08, '{8'h7F, 1'b0, 1'b1, 1'b0}, 7};
    vecs[4] = '{8'h08, 8'h70, '{8'h00, 1'b0, 1'b0, 1'b1}, 7};
    vecs[5] = '{8'hB8, 8'h00, '{8'hFF, 1'b1, 1'b0, 1'b0}, 0};
    vecs[6] = '{8'h00, 8'h30, '{8'h00, 1'b0, 1'b0, 1'b0}, 0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    #12;
    check("rst_in_ready",  32'(bus.in_ready),    32'd1);
    check("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check_res("rst", '{8'h00, 1'b0, 1'b0, 1'b0});

    // First operand pair is offered straight after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b);
      wait_result(lat);
      // Latency counted in edges after accept; 0 means valid in the first cycle after accept.
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
      check_res($sformatf("vec%0d", i), vecs[i].exp_res);
      consume();
    end

    // Backpressure, and an in_valid pulse during DIVIDE that must be ignored.
    send(8'h30, 8'h38);
    bus.a = 8'h70;
    bus.b = 8'h08;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("divide_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check_res("bp", '{8'h25, 1'b0, 1'b0, 1'b0});
    end
    consume();

    // Asynchronous reset during DIVIDE step 3 abandons the operation.
    send(8'h38, 8'h30);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_res("midrst", '{8'h00, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_cnt++;
    end
    check("midrst_no_out_valid", 32'(ov_cnt), 32'd0);
    send(8'h38, 8'h30);
    wait_result(lat);
    check("post_rst_latency", 32'(lat), 32'd7);
    check_res("post_rst", '{8'h38, 1'b0, 1'b0, 1'b0});
    consume();

    // Random operands against the arithmetic model.
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      if ($urandom_range(0, 9) == 0) ra = 8'h00;
      exp_r = model(ra, rb);
      send(ra, rb);
      wait_result(lat);
      check($sformatf("rnd%0d_latency a=%0h b=%0h", i, ra, rb), 32'(lat),
            (rb == 8'h00 || ra == 8'h00) ? 32'd0 : 32'd7);
      check_res($sformatf("rnd%0d a=%0h b=%0h", i, ra, rb), exp_r);
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
